// File: rtl/pet_key_matrix.sv
// pet_key_matrix: far end of the PET row-scan keyboard port.
// Host key events are queued and applied to an 80-key array, one per hold window.
module pet_key_matrix #(
   parameter int FIFO_DEPTH  = 8,
   parameter int HOLD_CYCLES = 800000,
   parameter int HOLD_W      = 20
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ev_valid,
   output logic       ev_ready,
   input  logic [6:0] ev_code,
   input  logic       ev_break,
   input  logic       ev_clear,
   input  logic [3:0] keyrow,
   output logic [7:0] keyin,
   output logic       busy
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

   typedef enum logic {
      IDLE,
      HOLD
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [8:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              push;
   logic              pop;

   logic              head_clear;
   logic              head_break;
   logic [3:0]        head_row;
   logic [2:0]        head_col;

   logic [HOLD_W-1:0] hold_cnt;
   logic              hold_load;
   logic              hold_dec;

   logic [9:0][7:0]   key_state;
   logic [7:0]        row_data;

   // Readiness depends on occupancy only, never on a same-cycle pop.
   assign ev_ready = (count != FULL);
   assign push     = ev_valid && ev_ready;
   assign pop      = (state == IDLE) && (count != '0);
   assign busy     = (count != '0) || (state == HOLD);

   assign {head_clear, head_break, head_row, head_col} = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {ev_clear, ev_break, ev_code};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (pop) state_nxt = HOLD;
         HOLD: if (hold_cnt == '0) state_nxt = IDLE;
      endcase
   end

   always_comb begin
      hold_load = 1'b0;
      hold_dec  = 1'b0;
      case (state)
         IDLE: hold_load = pop;
         HOLD: hold_dec  = (hold_cnt != '0);
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         hold_cnt <= '0;
      else if (hold_load)
         hold_cnt <= HOLD_LOAD;
      else if (hold_dec)
         hold_cnt <= hold_cnt - 1'b1;
   end

   // Rows 10-15 match no entry, so those events only consume a hold window.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_state <= '0;
      end else if (pop) begin
         for (int r = 0; r < 10; r++) begin
            if (head_clear)
               key_state[r] <= '0;
            else if (head_row == 4'(r))
               key_state[r][head_col] <= ~head_break;
         end
      end
   end

   always_comb begin
      row_data = 8'hFF;
      for (int r = 0; r < 10; r++) begin
         if (keyrow == 4'(r))
            row_data = ~key_state[r];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         keyin <= 8'hFF;
      else
         keyin <= row_data;
   end

endmodule

// File: tb/tb_pet_key_matrix.sv
// tb_pet_key_matrix: directed scoreboard bench for pet_key_matrix.
// Expected keyin values are scheduled from a key model when events are queued.
module tb_pet_key_matrix;

   typedef struct packed {
      logic       clr;
      logic       brk;
      logic [6:0] code;
   } ev_t;

   typedef struct {
      int         cyc;
      logic [7:0] val;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       ev_valid;
   logic       ev_ready;
   logic [6:0] ev_code;
   logic       ev_break;
   logic       ev_clear;
   logic [3:0] keyrow;
   logic [7:0] keyin;
   logic       busy;

   int n_assert = 0;
   int n_fail = 0;
   int cyc = 0;
   int busy_cycles;
   int p0;
   logic acc;
   logic [7:0] cur;
   logic [7:0] model [16];

   ev_t  ev_q [$];
   exp_t sb [$];
   exp_t rq [$];

   pet_key_matrix #(
      .FIFO_DEPTH (8),
      .HOLD_CYCLES(4),
      .HOLD_W     (20)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ev_valid(ev_valid),
      .ev_ready(ev_ready),
      .ev_code (ev_code),
      .ev_break(ev_break),
      .ev_clear(ev_clear),
      .keyrow  (keyrow),
      .keyin   (keyin),
      .busy    (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] expv);
      n_assert++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] row_exp(input logic [3:0] r);
      if (r <= 4'd9)
         return ~model[r];
      return 8'hFF;
   endfunction

   function automatic void model_clear();
      for (int r = 0; r < 16; r++)
         model[r] = 8'h00;
   endfunction

   function automatic void model_apply(input ev_t e);
      if (e.clr)
         model_clear();
      else if (e.code[6:3] <= 4'd9)
         model[e.code[6:3]][e.code[2:0]] = ~e.brk;
   endfunction

   task automatic send(input logic [6:0] code, input logic brk,
                       input logic clr);
      ev_t e;
      e.code = code;
      e.brk  = brk;
      e.clr  = clr;
      ev_q.push_back(e);
   endtask

   // Queued events start streaming on the next sample; the FIFO never
   // runs dry, so applies land every HOLD_CYCLES+1 = 5 cycles.
   task automatic plan();
      exp_t x;
      p0 = cyc + 1;
      for (int k = 0; k < ev_q.size(); k++) begin
         model_apply(ev_q[k]);
         x.cyc = p0 + 3 + 5 * k;
         x.val = row_exp(keyrow);
         sb.push_back(x);
      end
   endtask

   task automatic ready_at(input int c, input logic v);
      exp_t x;
      x.cyc = c;
      x.val = {7'd0, v};
      rq.push_back(x);
   endtask

   task automatic run(input int n, input string tag);
      exp_t x;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (acc)
            void'(ev_q.pop_front());
         while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            x = sb.pop_front();
            cur = x.val;
         end
         chk(tag, keyin, cur);
         while (rq.size() != 0 && rq[0].cyc <= cyc) begin
            x = rq.pop_front();
            chk({tag, "_ready"}, {7'd0, ev_ready}, x.val);
         end
         busy_cycles += int'(busy);
         if (ev_q.size() != 0) begin
            ev_valid = 1'b1;
            ev_code  = ev_q[0].code;
            ev_break = ev_q[0].brk;
            ev_clear = ev_q[0].clr;
         end else begin
            ev_valid = 1'b0;
         end
         acc = ev_valid && ev_ready;
      end
   endtask

   task automatic scan_rows(input string tag);
      for (int r = 0; r < 16; r++) begin
         keyrow = 4'(r);
         @(posedge clk);
         #1;
         chk(tag, keyin, row_exp(4'(r)));
      end
   endtask

   initial begin
      exp_t x;
      reset_n  = 1'b0;
      ev_valid = 1'b0;
      ev_code  = '0;
      ev_break = 1'b0;
      ev_clear = 1'b0;
      keyrow   = 4'd0;
      acc      = 1'b0;
      cur      = 8'hFF;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_keyin", keyin, 8'hFF);
      chk("rst_ready", {7'd0, ev_ready}, 8'h01);
      chk("rst_busy", {7'd0, busy}, 8'h00);
      @(negedge clk);
      reset_n = 1'b1;
      run(3, "idle");

      // Single press, row 2 col 3, then look at another row.
      keyrow = 4'd2;
      send(7'h13, 1'b0, 1'b0);
      plan();
      run(10, "press13");
      keyrow = 4'd3;
      x.cyc = cyc + 1;
      x.val = row_exp(4'd3);
      sb.push_back(x);
      run(3, "row3");

      // Back-to-back events with push/pop overlap at count 1.
      keyrow = 4'd0;
      cur = row_exp(4'd0);
      send(7'h00, 1'b0, 1'b0);
      send(7'h01, 1'b0, 1'b0);
      send(7'h00, 1'b1, 1'b0);
      plan();
      busy_cycles = 0;
      run(20, "b2b");
      chk("b2b_busy_len", 8'(busy_cycles), 8'd15);

      // Twelve streamed events overrun the 8-entry FIFO.
      for (int c = 0; c < 8; c++)
         send(7'(c), 1'b0, 1'b0);
      for (int c = 0; c < 4; c++)
         send(7'(c), 1'b1, 1'b0);
      plan();
      ready_at(p0 + 9, 1'b1);
      ready_at(p0 + 10, 1'b0);
      ready_at(p0 + 11, 1'b0);
      ready_at(p0 + 12, 1'b1);
      run(64, "full");

      // Keys in rows 0, 5 and 9, then clear everything.
      send(7'h05, 1'b0, 1'b0);
      send(7'h2A, 1'b0, 1'b0);
      send(7'h4F, 1'b0, 1'b0);
      send(7'h00, 1'b0, 1'b1);
      plan();
      run(25, "clear");
      scan_rows("scan_clear");

      // Row 11 press: no state change, hold still timed.
      keyrow = 4'd11;
      cur = 8'hFF;
      send(7'h58, 1'b0, 1'b0);
      plan();
      busy_cycles = 0;
      run(10, "row11");
      chk("row11_busy_len", 8'(busy_cycles), 8'd5);
      scan_rows("scan_row11");

      // Reset mid-hold with three events still queued.
      keyrow = 4'd0;
      cur = row_exp(4'd0);
      send(7'h00, 1'b0, 1'b0);
      send(7'h01, 1'b0, 1'b0);
      send(7'h02, 1'b0, 1'b0);
      send(7'h03, 1'b0, 1'b0);
      plan();
      run(5, "pre_rst");
      chk("pre_rst_busy", {7'd0, busy}, 8'h01);
      chk("pre_rst_ready", {7'd0, ev_ready}, 8'h01);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_keyin", keyin, 8'hFF);
      chk("mid_rst_ready", {7'd0, ev_ready}, 8'h01);
      chk("mid_rst_busy", {7'd0, busy}, 8'h00);
      sb.delete();
      model_clear();
      acc = 1'b0;
      cur = 8'hFF;
      @(negedge clk);
      reset_n = 1'b1;
      run(30, "post_rst");
      chk("post_rst_busy", {7'd0, busy}, 8'h00);
      scan_rows("scan_rst");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
